// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard and zero sweep (option: REGFILE_BYPASS_EN)
module regfile_mp #(
    parameter  int XLEN   = 64,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    output logic                    ready_o,
    input  logic [NREAD*AW-1:0]     rd_addr_i,
    output logic [NREAD*XLEN-1:0]   rd_data_o,
    output logic [NREAD-1:0]        rd_busy_o,
    input  logic [NWRITE-1:0]       wr_en_i,
    input  logic [NWRITE*AW-1:0]    wr_addr_i,
    input  logic [NWRITE*XLEN-1:0]  wr_data_i,
    input  logic                    issue_en_i,
    input  logic [AW-1:0]           issue_addr_i
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_sweep_idx;
    logic [NREGS-1:0]   r_busy;
    logic [XLEN-1:0]    r_regs [NREGS];

    assign ready_o = (r_state == ST_RUN);

    // Storage: zero one entry per cycle while sweeping, otherwise apply writebacks (last port wins)
    always_ff @(posedge clk_i) begin
        if (r_state == ST_CLEAR) begin
            r_regs[r_sweep_idx] <= '0;
        end else if (!clear_i) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0)) begin
                    r_regs[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Sweep sequencing and scoreboard; an issue overrides a same-cycle write to the same register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_CLEAR;
            r_sweep_idx <= '0;
            r_busy      <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_sweep_idx <= r_sweep_idx + 1'b1;
                    if (r_sweep_idx == AW'(NREGS - 1)) begin
                        r_state     <= ST_RUN;
                        r_sweep_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (clear_i) begin
                        r_state     <= ST_CLEAR;
                        r_sweep_idx <= '0;
                        r_busy      <= '0;
                    end else begin
                        for (int k = 0; k < NWRITE; k++) begin
                            if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0)) begin
                                r_busy[wr_addr_i[k*AW +: AW]] <= 1'b0;
                            end
                        end
                        if (issue_en_i && (issue_addr_i != '0)) begin
                            r_busy[issue_addr_i] <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_sweep_idx <= '0;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_ra = rd_addr_i[p*AW +: AW];
        assign rd_data_o[p*XLEN +: XLEN] = w_data;
        assign rd_busy_o[p] = w_busy;

        // Read port: x0 and the sweep read as zero; optional forwarding from same-cycle writes
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if ((r_state == ST_RUN) && (w_ra != '0)) begin
                w_data = r_regs[w_ra];
                w_busy = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
                if (!clear_i) begin
                    for (int k = 0; k < NWRITE; k++) begin
                        if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == w_ra)) begin
                            w_data = wr_data_i[k*XLEN +: XLEN];
                            w_busy = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (NWRITE=2)
module tb_regfile_mp;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clear;
    logic                   ready;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   issue_en;
    logic [AW-1:0]          issue_addr;

    int n_chk = 0;
    int n_err = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .ready_o      (ready),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr)
    );

    always #5 clk = ~clk;

    // Reference model: register contents, busy flags and cycles left until ready
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= NREGS;
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] <= '0;
                m_busy[r] <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (clear) begin
            m_left <= NREGS;
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] <= '0;
                m_busy[r] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en[k] && wr_addr[k*AW +: AW] != 0) begin
                    m_regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                    m_busy[wr_addr[k*AW +: AW]] <= 1'b0;
                end
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_read(input int p, output logic [XLEN-1:0] d, output logic b);
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        d = '0;
        b = 1'b0;
        if (rst_n && m_left == 0 && a != 0) begin
            d = m_regs[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (!clear) begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (wr_en[k] && wr_addr[k*AW +: AW] == a) begin
                        d = wr_data[k*XLEN +: XLEN];
                        b = 1'b0;
                    end
                end
            end
`endif
        end
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [XLEN-1:0] ed;
        logic            eb;
        if (rst_n !== 1'bx) begin
            chk("ready", {63'd0, ready}, {63'd0, (rst_n && m_left == 0)});
            for (int p = 0; p < NREAD; p++) begin
                model_read(p, ed, eb);
                chk($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], ed);
                chk($sformatf("rd_busy[%0d]", p), {63'd0, rd_busy[p]}, {63'd0, eb});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int k, input bit en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[k] = en;
        wr_addr[k*AW +: AW] = a;
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready === 1'b1) return;
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'bx;
        clear = 0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 0; issue_addr = '0;
        #1 rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // 1: reset and initial sweep
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(n);
        chk("sweep_len_reset", 64'(n), 64'd32);

        // 2: write x5, read back; write x0 is dropped
        step();
        set_wr(0, 1, 5'd5, 64'hDEAD_BEEF_0123_4567);
        set_rd(0, 5'd5);
        step();
        set_wr(0, 0, 0, 0);
        @(negedge clk);
        chk("x5_read", rd_data[0 +: XLEN], 64'hDEAD_BEEF_0123_4567);
        step();
        set_wr(0, 1, 5'd0, 64'h1);
        set_rd(1, 5'd0);
        step();
        set_wr(0, 0, 0, 0);
        @(negedge clk);
        chk("x0_read", rd_data[XLEN +: XLEN], 64'h0);

        // 3: both write ports hit x7, port 1 wins
        step();
        set_wr(0, 1, 5'd7, 64'h11);
        set_wr(1, 1, 5'd7, 64'h22);
        step();
        set_wr(0, 0, 0, 0);
        set_wr(1, 0, 0, 0);
        set_rd(0, 5'd7);
        @(negedge clk);
        chk("x7_priority", rd_data[0 +: XLEN], 64'h22);

        // 4: issue x9, then write it back
        step();
        issue_en = 1; issue_addr = 5'd9;
        step();
        issue_en = 0;
        set_rd(0, 5'd9);
        @(negedge clk);
        chk("x9_busy", {63'd0, rd_busy[0]}, 64'd1);
        step();
        set_wr(0, 1, 5'd9, 64'h5);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("x9_bypass_data", rd_data[0 +: XLEN], 64'h5);
        chk("x9_bypass_busy", {63'd0, rd_busy[0]}, 64'd0);
`else
        chk("x9_old_data", rd_data[0 +: XLEN], 64'h0);
        chk("x9_old_busy", {63'd0, rd_busy[0]}, 64'd1);
`endif
        step();
        set_wr(0, 0, 0, 0);
        @(negedge clk);
        chk("x9_after_data", rd_data[0 +: XLEN], 64'h5);
        chk("x9_after_busy", {63'd0, rd_busy[0]}, 64'd0);

        // 5: same-cycle issue and write keeps busy; clear sweep ignores traffic
        step();
        issue_en = 1; issue_addr = 5'd3;
        set_wr(0, 1, 5'd3, 64'h33);
        step();
        issue_en = 0;
        set_wr(0, 0, 0, 0);
        set_rd(1, 5'd3);
        @(negedge clk);
        chk("x3_busy_kept", {63'd0, rd_busy[1]}, 64'd1);
        chk("x3_data", rd_data[XLEN +: XLEN], 64'h33);
        step();
        clear = 1;
        set_wr(0, 1, 5'd8, 64'h88);
        issue_en = 1; issue_addr = 5'd8;
        step();
        clear = 0;
        set_wr(0, 1, 5'd10, 64'hAA);
        issue_addr = 5'd10;
        wait_ready(n);
        chk("sweep_len_clear", 64'(n), 64'd32);
        #1;
        set_wr(0, 0, 0, 0);
        issue_en = 0;
        chk("x3_cleared_data", rd_data[XLEN +: XLEN], 64'h0);
        chk("x3_cleared_busy", {63'd0, rd_busy[1]}, 64'd0);
        set_rd(0, 5'd8);
        set_rd(1, 5'd10);
        @(negedge clk);
        chk("x8_ignored", rd_data[0 +: XLEN], 64'h0);
        chk("x10_ignored", rd_data[XLEN +: XLEN], 64'h0);
        chk("x10_busy_ignored", {63'd0, rd_busy[1]}, 64'd0);

        // 6: asynchronous reset from RUN and in the middle of a sweep
        step();
        set_wr(0, 1, 5'd4, 64'h44);
        step();
        set_wr(0, 0, 0, 0);
        issue_en = 1; issue_addr = 5'd4;
        step();
        issue_en = 0;
        set_rd(0, 5'd4);
        @(negedge clk);
        chk("x4_data", rd_data[0 +: XLEN], 64'h44);
        chk("x4_busy", {63'd0, rd_busy[0]}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_data", rd_data[0 +: XLEN], 64'h0);
        chk("rst_busy", {63'd0, rd_busy[0]}, 64'd0);
        @(posedge clk);
        step();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midsweep_ready", {63'd0, ready}, 64'd0);
        step();
        rst_n = 1'b1;
        wait_ready(n);
        chk("sweep_len_restart", 64'(n), 64'd32);
        chk("x4_after_reset", rd_data[0 +: XLEN], 64'h0);
        chk("x4_busy_after_reset", {63'd0, rd_busy[0]}, 64'd0);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
